mac_sequencer: RTL and testbench
================================

Name: mac_sequencer

Overview:
- Initiator side of the MAC accumulator control interface.
- On a start pulse, issues one operand address pair per cycle to the coefficient and sample memories, which feed the multiplier.
- Drives the 2-bit accumulator control code, time-aligned to the multiplier pipeline, so the accumulator builds one dot product of len terms. Optionally negates the final result.
- Sits between the decoder-stage FSMs (synthesis filterbank, IMDCT windowing) and the mac_unit datapath.

Parameters:
ADDR_WIDTH, 9, width of both operand address buses
LEN_WIDTH, 6, width of the term-count input
MULT_LATENCY, 2, cycles from rd_en/address issue to the matching product at the accumulator add_in2 input; legal range 1..4

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
len  input  LEN_WIDTH  number of products; 0 is legal
base_a  input  ADDR_WIDTH  first coefficient address
base_b  input  ADDR_WIDTH  first sample address
dir_b  input  1  0 = addr_b increments, 1 = addr_b decrements
negate  input  1  complement the final sum
rd_en  output  1  operand read strobe
addr_a  output  ADDR_WIDTH  coefficient address
addr_b  output  ADDR_WIDTH  sample address
control  output  2  accumulator control code (`ACCUMULATOR_* codes from defines.v)
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse; accumulator output is final in this cycle

Behaviour:
- Interface: one clock domain. Reset is asynchronous, active-low, on resetn. Clock port is named clock.
- Reset values: rd_en=0, addr_a=0, addr_b=0, busy=0, done=0, control=`ACCUMULATOR_HOLD, state=IDLE, tag pipeline cleared. Reset mid-operation aborts immediately; there is no partial done.
- States:
  - IDLE: on start, latch len, base_a, base_b, dir_b and negate, then go to ISSUE. If len=0, go to FIN instead.
  - ISSUE: rd_en=1 for exactly len cycles. First cycle presents base_a/base_b. Each later cycle: addr_a+1, addr_b+1 or -1. Both wrap modulo 2^ADDR_WIDTH. Leave for DRAIN after the len-th issue.
  - DRAIN: rd_en=0; wait until the tag pipeline is empty. Then go to NEG if negate was latched, else FIN.
  - NEG: one cycle with control=`ACCUMULATOR_COMPLEMENT`, then FIN.
  - FIN: done=1, busy=0 for one cycle, then IDLE.
- Control alignment:
  - An MULT_LATENCY-deep shift register carries {valid, first} for each issue.
  - At its output: first gives `ACCUMULATOR_LOAD`; valid and not first gives the accumulate code (the default case); no valid gives `ACCUMULATOR_HOLD`.
  - NEG overrides the pipeline output, which is empty by then.
- Timing (start high in cycle 0):
  - Issues occur in cycles 1..len.
  - LOAD occurs in cycle 1+MULT_LATENCY.
  - The last accumulate occurs in cycle len+MULT_LATENCY.
  - COMPLEMENT (if enabled) occurs in cycle len+MULT_LATENCY+1.
  - done occurs one cycle after the last non-HOLD control.
- len=0: no reads, control stays HOLD, done occurs in cycle 1, accumulator unchanged. negate is ignored.
- start while busy is ignored; no queueing.
- start asserted in the same cycle as FIN is ignored. It must be re-presented in IDLE.
- control is HOLD whenever the block is idle.

Optional Feature:
- Macro: MAC_SEQ_CONTINUE_EN.
- With the macro: add input port cont (1 bit), latched at start. When cont=1, the first product uses the accumulate code instead of LOAD. This extends the current accumulator value, so sums longer than 2^LEN_WIDTH-1 terms can be split.
- Without the macro: no cont port; the first product always uses LOAD.

Test Plan (MULT_LATENCY=2):
- Basic run: start with len=3, base_a=0x010, base_b=0x020, dir_b=0, negate=0.
  - addr pairs (0x010,0x020), (0x011,0x021), (0x012,0x022) in cycles 1-3.
  - control LOAD in cycle 3, accumulate in cycles 4-5.
  - done in cycle 6.
  - Accumulator holds the sum of the 3 products.
- Reverse addressing with negate: len=2, base_b=0x000, dir_b=1, negate=1.
  - addr_b = 0x000 then 0x1FF.
  - COMPLEMENT in cycle 5, done in cycle 6.
  - acc_out equals -(p0+p1).
- Empty request: len=0 -> rd_en never high, control HOLD throughout, done in cycle 1, acc_out unchanged.
- Re-triggering:
  - start pulsed in cycles 2 and 4 of a len=4 run -> ignored; exactly 4 reads occur.
  - start in the FIN cycle -> ignored.
  - start in the following IDLE cycle -> accepted.
- Reset mid-operation: resetn low in cycle 2 of a len=5 run -> outputs return to reset values asynchronously, no done. A new start after release runs normally.
- With MAC_SEQ_CONTINUE_EN: two len=3 runs, the second with cont=1 -> no LOAD in the second run; acc_out equals the sum of all 6 products.

Source files
------------

// File: rtl/mac_sequencer.sv
// mac_sequencer: issues operand address pairs for one dot product and drives the accumulator
// control code aligned to the multiplier pipeline. Build option MAC_SEQ_CONTINUE_EN adds the cont input.
`ifndef ACCUMULATOR_HOLD
`define ACCUMULATOR_HOLD       2'b00
`endif
`ifndef ACCUMULATOR_LOAD
`define ACCUMULATOR_LOAD       2'b01
`endif
`ifndef ACCUMULATOR_ACCUMULATE
`define ACCUMULATOR_ACCUMULATE 2'b10
`endif
`ifndef ACCUMULATOR_COMPLEMENT
`define ACCUMULATOR_COMPLEMENT 2'b11
`endif

// state | meaning
// IDLE  | waiting for start, control held
// ISSUE | one operand read per cycle for len cycles
// DRAIN | reads finished, waiting for the tag pipeline to empty
// NEG   | complement the accumulated sum
// FIN   | done pulse, then back to IDLE
module mac_sequencer #(
  parameter int ADDR_WIDTH   = 9,
  parameter int LEN_WIDTH    = 6,
  parameter int MULT_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  input  logic                  dir_b,
  input  logic                  negate,
`ifdef MAC_SEQ_CONTINUE_EN
  input  logic                  cont,
`endif
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [1:0]            control,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_NEG,
    S_FIN
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);

  state_t                  state_q;
  logic [LEN_WIDTH-1:0]    cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_a_q;
  logic [ADDR_WIDTH-1:0]   addr_b_q;
  logic                    dir_q;
  logic                    neg_q;
  logic                    first_q;
  logic                    rd_en_q;
  logic                    busy_q;
  logic                    done_q;
  logic [MULT_LATENCY-1:0] tag_v_q;
  logic [MULT_LATENCY-1:0] tag_f_q;
  logic                    first_init;
  logic                    drain_clear;

`ifdef MAC_SEQ_CONTINUE_EN
  assign first_init = ~cont;
`else
  assign first_init = 1'b1;
`endif

  // The last stage is being consumed this cycle, so only the earlier stages must be empty.
  always_comb begin
    drain_clear = 1'b1;
    for (int i = 0; i < MULT_LATENCY - 1; i++) begin
      if (tag_v_q[i]) drain_clear = 1'b0;
    end
  end

  always_comb begin
    control = `ACCUMULATOR_HOLD;
    if (state_q == S_NEG) begin
      control = `ACCUMULATOR_COMPLEMENT;
    end else if (tag_v_q[MULT_LATENCY-1]) begin
      control = tag_f_q[MULT_LATENCY-1] ? `ACCUMULATOR_LOAD : `ACCUMULATOR_ACCUMULATE;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      dir_q    <= 1'b0;
      neg_q    <= 1'b0;
      first_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tag_v_q  <= '0;
      tag_f_q  <= '0;
    end else begin
      for (int i = MULT_LATENCY - 1; i > 0; i--) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_f_q[i] <= tag_f_q[i-1];
      end
      tag_v_q[0] <= rd_en_q;
      tag_f_q[0] <= rd_en_q & first_q;
      done_q     <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q    <= len;
            addr_a_q <= base_a;
            addr_b_q <= base_b;
            dir_q    <= dir_b;
            neg_q    <= negate;
            first_q  <= first_init;
            if (len == '0) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ISSUE;
              rd_en_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          first_q <= 1'b0;
          if (cnt_q == LEN_ONE) begin
            rd_en_q <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            cnt_q    <= cnt_q - LEN_ONE;
            addr_a_q <= addr_a_q + ADDR_ONE;
            addr_b_q <= dir_q ? (addr_b_q - ADDR_ONE) : (addr_b_q + ADDR_ONE);
          end
        end
        S_DRAIN: begin
          if (drain_clear) begin
            if (neg_q) begin
              state_q <= S_NEG;
            end else begin
              state_q <= S_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        S_NEG: begin
          state_q <= S_FIN;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_en  = rd_en_q;
  assign addr_a = addr_a_q;
  assign addr_b = addr_b_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: a small memory/multiplier/accumulator model follows the
// control code, and per-cycle logs are checked against hand-computed expectations.
module tb_mac_sequencer;

  localparam int AW = 9;
  localparam int LW = 6;
  localparam int ML = 2;

  localparam logic [1:0] C_HOLD = 2'b00;
  localparam logic [1:0] C_LOAD = 2'b01;
  localparam logic [1:0] C_ACC  = 2'b10;
  localparam logic [1:0] C_COMP = 2'b11;

  logic          clock  = 1'b0;
  logic          resetn = 1'b0;
  logic          start  = 1'b0;
  logic [LW-1:0] len    = '0;
  logic [AW-1:0] base_a = '0;
  logic [AW-1:0] base_b = '0;
  logic          dir_b  = 1'b0;
  logic          negate = 1'b0;
`ifdef MAC_SEQ_CONTINUE_EN
  logic          cont   = 1'b0;
`endif

  logic          rd_en;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic [1:0]    control;
  logic          busy;
  logic          done;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  mac_sequencer #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MULT_LATENCY(ML)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .start   (start),
    .len     (len),
    .base_a  (base_a),
    .base_b  (base_b),
    .dir_b   (dir_b),
    .negate  (negate),
`ifdef MAC_SEQ_CONTINUE_EN
    .cont    (cont),
`endif
    .rd_en   (rd_en),
    .addr_a  (addr_a),
    .addr_b  (addr_b),
    .control (control),
    .busy    (busy),
    .done    (done)
  );

  // Datapath model: coefficient = address, sample = low nibble + 1, product reaches the
  // accumulator ML cycles after the read.
  int acc = 0;
  int prod_p[ML];

  function automatic int mem_a(input logic [AW-1:0] a);
    return int'(a);
  endfunction

  function automatic int mem_b(input logic [AW-1:0] a);
    return int'(a[3:0]) + 1;
  endfunction

  initial for (int i = 0; i < ML; i++) prod_p[i] = 0;

  always @(posedge clock) begin
    case (control)
      C_LOAD:  acc = prod_p[ML-1];
      C_ACC:   acc = acc + prod_p[ML-1];
      C_COMP:  acc = -acc;
      default: acc = acc;
    endcase
    for (int i = ML - 1; i > 0; i--) prod_p[i] = prod_p[i-1];
    prod_p[0] = rd_en ? mem_a(addr_a) * mem_b(addr_b) : 0;
  end

  logic          log_rd[32];
  logic [AW-1:0] log_a[32];
  logic [AW-1:0] log_b[32];
  logic [1:0]    log_c[32];
  logic          log_d[32];
  logic          log_bz[32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  // Cycle 0 is the first cycle start is sampled; smask bit i drives start in cycle i.
  task automatic run_seq(input logic [LW-1:0] l, input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                         input logic d, input logic n, input logic [31:0] smask, input int ncyc);
    @(posedge clock); #1;
    len    = l;
    base_a = ba;
    base_b = bb;
    dir_b  = d;
    negate = n;
    for (int i = 0; i < ncyc; i++) begin
      start = smask[i];
      @(negedge clock);
      log_rd[i] = rd_en;
      log_a[i]  = addr_a;
      log_b[i]  = addr_b;
      log_c[i]  = control;
      log_d[i]  = done;
      log_bz[i] = busy;
      @(posedge clock); #1;
    end
    start = 1'b0;
  endtask

  function automatic int count_rd(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (log_rd[i]) n++;
    return n;
  endfunction

  function automatic int count_ctl(input logic [1:0] code, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (log_c[i] == code) n++;
    return n;
  endfunction

  function automatic int count_done(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (log_d[i]) n++;
    return n;
  endfunction

  function automatic int first_done(input int ncyc);
    for (int i = 0; i < ncyc; i++) if (log_d[i]) return i;
    return -1;
  endfunction

  logic [AW-1:0] exp_a[3];
  logic [AW-1:0] exp_b[3];
  int            done_seen;

  initial begin
    exp_a = '{9'h010, 9'h011, 9'h012};
    exp_b = '{9'h020, 9'h021, 9'h022};

    // reset values
    #12;
    check("rst_rd_en",   32'(rd_en),   0);
    check("rst_addr",    32'({addr_a, addr_b}), 0);
    check("rst_control", 32'(control), 32'(C_HOLD));
    check("rst_busy_done", 32'({busy, done}), 0);
    @(negedge clock);
    resetn = 1'b1;

    // basic run: len=3, forward
    run_seq(6'd3, 9'h010, 9'h020, 1'b0, 1'b0, 32'h1, 8);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("basic_addr_c%0d", i + 1), 32'({log_a[i+1], log_b[i+1]}),
            32'({exp_a[i], exp_b[i]}));
    end
    check("basic_rd_count", count_rd(0, 7), 3);
    check("basic_ctl_c2",   32'(log_c[2]), 32'(C_HOLD));
    check("basic_ctl_c3",   32'(log_c[3]), 32'(C_LOAD));
    check("basic_ctl_c4",   32'(log_c[4]), 32'(C_ACC));
    check("basic_ctl_c5",   32'(log_c[5]), 32'(C_ACC));
    check("basic_ctl_c6",   32'(log_c[6]), 32'(C_HOLD));
    check("basic_done_cyc", first_done(8), 6);
    check("basic_done_cnt", count_done(0, 7), 1);
    check("basic_busy_c1",  32'(log_bz[1]), 1);
    check("basic_busy_c6",  32'(log_bz[6]), 0);
    check("basic_acc",      acc, 104);

    // reverse addressing with negate: len=2
    run_seq(6'd2, 9'h005, 9'h000, 1'b1, 1'b1, 32'h1, 8);
    check("rev_addr_b_c1",  32'(log_b[1]), 32'h000);
    check("rev_addr_b_c2",  32'(log_b[2]), 32'h1FF);
    check("rev_ctl_c3",     32'(log_c[3]), 32'(C_LOAD));
    check("rev_ctl_c4",     32'(log_c[4]), 32'(C_ACC));
    check("rev_ctl_c5",     32'(log_c[5]), 32'(C_COMP));
    check("rev_done_cyc",   first_done(8), 6);
    check("rev_acc",        acc, -101);

    // empty request: len=0 with negate set
    run_seq(6'd0, 9'h033, 9'h044, 1'b0, 1'b1, 32'h1, 6);
    check("empty_rd_count", count_rd(0, 5), 0);
    check("empty_ctl_hold", count_ctl(C_HOLD, 0, 5), 6);
    check("empty_done_cyc", first_done(6), 1);
    check("empty_done_cnt", count_done(0, 5), 1);
    check("empty_acc",      acc, -101);

    // re-triggering: starts in cycles 2,4 (busy), 7 (FIN) ignored; cycle 8 (IDLE) accepted
    run_seq(6'd4, 9'h030, 9'h000, 1'b0, 1'b0, 32'h195, 16);
    check("retrig_rd_first",  count_rd(0, 8), 4);
    check("retrig_done1_cyc", first_done(16), 7);
    check("retrig_rd_c8",     32'(log_rd[8]), 0);
    check("retrig_busy_c8",   32'(log_bz[8]), 0);
    check("retrig_rd_c9",     32'(log_rd[9]), 1);
    check("retrig_addr_c9",   32'({log_a[9], log_b[9]}), 32'({9'h030, 9'h000}));
    check("retrig_rd_total",  count_rd(0, 15), 8);
    check("retrig_done_c15",  32'(log_d[15]), 1);
    check("retrig_done_cnt",  count_done(0, 15), 2);
    check("retrig_acc",       acc, 500);

    // reset mid-operation: len=5, resetn low during cycle 2
    @(posedge clock); #1;
    len = 6'd5; base_a = 9'h040; base_b = 9'h010; dir_b = 1'b0; negate = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    check("midrst_pre_rd",   32'({rd_en, addr_a}), 32'({1'b1, 9'h041}));
    #1 resetn = 1'b0;
    #1;
    check("midrst_rd_en",    32'(rd_en), 0);
    check("midrst_addr",     32'({addr_a, addr_b}), 0);
    check("midrst_busy",     32'(busy), 0);
    check("midrst_control",  32'(control), 32'(C_HOLD));
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (done) done_seen++;
    end
    @(posedge clock); #1;
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (done) done_seen++;
    end
    check("midrst_no_done",  done_seen, 0);
    run_seq(6'd1, 9'h002, 9'h003, 1'b0, 1'b0, 32'h1, 6);
    check("midrst_rerun_done", first_done(6), 4);
    check("midrst_rerun_ctl",  32'(log_c[3]), 32'(C_LOAD));
    check("midrst_rerun_acc",  acc, 8);

`ifdef MAC_SEQ_CONTINUE_EN
    // continuation: second len=3 run extends the first
    cont = 1'b0;
    run_seq(6'd3, 9'h010, 9'h020, 1'b0, 1'b0, 32'h1, 8);
    check("cont_run1_acc", acc, 104);
    cont = 1'b1;
    run_seq(6'd3, 9'h010, 9'h020, 1'b0, 1'b0, 32'h1, 8);
    cont = 1'b0;
    check("cont_no_load",  count_ctl(C_LOAD, 0, 7), 0);
    check("cont_acc_cnt",  count_ctl(C_ACC, 0, 7), 3);
    check("cont_acc",      acc, 208);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
